spi_wb_master: RTL and testbench
================================

# spi_wb_master

SPI-slave to Wishbone-master bridge that lets the external flight host reach the on-chip register peripherals (debug GPIO, PWM, etc.). It accepts fixed-format SPI mode-0 frames, issues exactly one classic single-beat Wishbone cycle per valid frame, and returns read data on MISO in the same frame. It sits directly upstream of the Wishbone slaves: its `wb_*` outputs drive the slave inputs, and its inputs are driven by the slave `wb_dat_o`/`wb_ack_o`.

## Interface
- ADDR_BASE, 32'h0000_0000 — OR'ed into every issued address
- TIMEOUT_CYCLES, 255 — clk cycles to wait for `wb_ack_i` before abandoning a cycle (8-bit counter minimum)
- clk  in  1  system clock; must be ≥ 8× SCK frequency
- rst  in  1  synchronous, active-high reset
- spi_sclk  in  1  SPI clock, asynchronous to clk
- spi_cs_n  in  1  chip select, active low, asynchronous
- spi_mosi  in  1  serial data in, asynchronous
- spi_miso  out  1  serial data out
- spi_miso_oe  out  1  MISO tri-state enable (1 while synchronized CS active)
- wb_adr_o  out  32  byte address = ADDR_BASE | {22'b0, A[7:0], 2'b00}
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_we_o  out  1  1 = write
- wb_sel_o  out  4  constant 4'hF
- wb_stb_o, wb_cyc_o  out  1  strobe/cycle, always asserted and dropped together
- wb_ack_i  in  1  slave acknowledge
- timeout_o  out  1  one-clk pulse when a cycle times out

## Operation
- spi_sclk, spi_cs_n, spi_mosi each pass through 2-FF synchronizers; SCK rise/fall detected from the synchronized value and its previous sample.
- Frame = bytes, MSB-first, counted by a 6-bit bit counter cleared on synchronized CS falling edge and on CS high.
  - Byte 0 CMD: bit7 = 1 write, 0 read; bits[6:0] ignored.
  - Byte 1 ADDR A: word index.
  - Write: bytes 2–5 = data MSB-first. WB write issued after the 48th rising edge. Frames shorter than 48 bits issue nothing.
  - Read: WB read issued after the 16th rising edge. Byte 2 is turnaround (MISO 0x00). Bytes 3–6 return read data MSB-first.
  - Bits beyond the frame length are ignored; MISO drives 0.
- Frame FSM states: FR_IDLE → FR_CMD → FR_ADDR → FR_DATA → FR_DRAIN. CS high in any state returns to FR_IDLE.
- Bus FSM states: BUS_IDLE → BUS_REQ (cyc/stb/we/adr/dat held) → BUS_IDLE.
  - Exit on `wb_ack_i`.
  - Exit on timeout counter reaching TIMEOUT_CYCLES: drop cyc/stb and pulse `timeout_o`.
- Read data register:
  - Preset to 32'hFFFF_FFFF when a read is issued.
  - Overwritten by `wb_dat_i` on ack.
- TX shift register:
  - Loaded from the read data register on the 24th rising edge.
  - On each SCK falling edge, MISO ← tx[31] and tx shifts left with 0 fill.
  - Outside the data window, tx = 0.
- A read still pending at the 24th edge (late ack or timeout) returns 0xFFFF_FFFF.
- CS deasserted mid-frame: frame aborts and no new cycle is issued. A cycle already in BUS_REQ runs to ack/timeout and is never aborted early.
- A new frame whose trigger edge arrives while BUS_REQ is busy is dropped (no queuing).

## Timing
- Pin edge to detected edge: 3 clk.
- `wb_cyc_o` asserts 1 clk after the triggering detected rising edge.
- Cycle ends the clk after `wb_ack_i` is sampled high; cyc/stb low for ≥ 1 clk between cycles.
- Reset values:
  - All `wb_*` outputs 0, except `wb_sel_o` = 4'hF.
  - `spi_miso` 0, `spi_miso_oe` 0, `timeout_o` 0.
  - Both FSMs idle; synchronizers preset CS = 1 and SCK = 0.
- Reset mid-cycle drops cyc/stb on the next clk.

## Structure
- Package `spi_wb_pkg`:
  - CMD_WRITE_BIT = 7
  - bit-count constants WR_ISSUE_BIT = 48, RD_ISSUE_BIT = 16, RD_LOAD_BIT = 24
  - RD_DEFAULT = 32'hFFFF_FFFF
  - enums frame_state_t, bus_state_t
- Sub-module `spi_sync_edge`: 2-FF synchronization of the three inputs plus SCK rise/fall pulses.

## Test plan
- Write frame 0x80, 0x00, 0x00000005 at SCK = clk/10 → one WB cycle with adr 0x0, dat 0x5, we = 1, sel 0xF; slave acks after 1 clk; gpio_out = 3'b101.
- Read frame 0x00, 0x00, 5 further bytes, slave ack after 2 clk returning 0x5 → MISO bytes 2–6 = 0x00, 0x00, 0x00, 0x00, 0x05.
- Read with slave never acking, TIMEOUT_CYCLES = 16 → cyc drops after 16 clk, `timeout_o` pulses once, MISO data bytes = 0xFF×4.
- Write frame with CS raised after 40 bits → no WB cycle; the next full write frame to A = 3 (adr 0xC) executes normally.
- Assert rst while `wb_cyc_o` = 1 → cyc/stb/miso_oe = 0 next clk; a subsequent frame works.
- Two back-to-back write frames to A = 1 (set, 0x1) and A = 2 (clr, 0x1), with 1 SCK period of CS high between them → two WB cycles in order; final gpio_out = 0.

Source files
------------

// File: rtl/spi_wb_pkg.sv
// Shared constants and state types for the SPI-to-Wishbone bridge.
// Frame bit positions are counted in SCK rising edges from CS low.
package spi_wb_pkg;

  localparam int CMD_WRITE_BIT = 7;

  localparam logic [5:0] CMD_END_BIT  = 6'd8;
  localparam logic [5:0] RD_ISSUE_BIT = 6'd16;
  localparam logic [5:0] RD_LOAD_BIT  = 6'd24;
  localparam logic [5:0] WR_ISSUE_BIT = 6'd48;
  localparam logic [5:0] RD_END_BIT   = 6'd56;
  localparam logic [5:0] CNT_MAX      = 6'h3F;

  localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [3:0]  WB_SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_CMD,
    FR_ADDR,
    FR_DATA,
    FR_DRAIN
  } frame_state_t;

  typedef enum logic {
    BUS_IDLE,
    BUS_REQ
  } bus_state_t;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [7:0]  a
  );
    return base | {22'b0, a, 2'b00};
  endfunction

endpackage

// File: rtl/spi_wb_if.sv
// Classic single-beat Wishbone bus bundle.
// master: adr/wdat/we/sel/stb/cyc out, rdat/ack in; slave mirrors it.
interface spi_wb_if;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output adr, wdat, we, sel, stb, cyc,
    input  rdat, ack
  );

  modport slave (
    input  adr, wdat, we, sel, stb, cyc,
    output rdat, ack
  );
endinterface

// File: rtl/spi_sync_edge.sv
// 2-FF synchronizers for SCK/CS/MOSI plus SCK rise/fall and CS fall pulses.
// Ports: clk, rst, raw pins in; synchronized CS/MOSI and edge pulses out.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic cs_n_o,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_fall_o
);

  logic [1:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic       sclk_prev_q;
  logic       cs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= 2'b00;
      cs_q        <= 2'b11;
      mosi_q      <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[0], sclk_i};
      cs_q        <= {cs_q[0], cs_n_i};
      mosi_q      <= {mosi_q[0], mosi_i};
      sclk_prev_q <= sclk_q[1];
      cs_prev_q   <= cs_q[1];
    end
  end

  assign cs_n_o     = cs_q[1];
  assign mosi_o     = mosi_q[1];
  assign sck_rise_o = sclk_q[1] & ~sclk_prev_q;
  assign sck_fall_o = ~sclk_q[1] & sclk_prev_q;
  assign cs_fall_o  = ~cs_q[1] & cs_prev_q;

endmodule

// File: rtl/spi_wb_master.sv
// SPI mode-0 slave that turns each frame into one Wishbone cycle.
// Ports: clk/rst, SPI pins, wb (master modport), timeout_o pulse.
module spi_wb_master
  import spi_wb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     spi_sclk,
  input  logic     spi_cs_n,
  input  logic     spi_mosi,
  output logic     spi_miso,
  output logic     spi_miso_oe,
  spi_wb_if.master wb,
  output logic     timeout_o
);

  localparam int unsigned TW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic cs_n_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic cs_fall;
  logic cs_act;
  logic rise;

  frame_state_t fr_q, fr_d;
  bus_state_t   bus_q, bus_d;

  logic [5:0]    cnt_q, cnt_d, cnt_nxt;
  logic [31:0]   sh_q, sh_d, sh_nxt;
  logic          wr_q, wr_d;
  logic [7:0]    a_q, a_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   tx_q, tx_d;
  logic          miso_q, miso_d;
  logic          to_q, to_d;

  logic iss_rd;
  logic iss_wr;
  logic ld_tx;

  spi_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .sclk_i     (spi_sclk),
    .cs_n_i     (spi_cs_n),
    .mosi_i     (spi_mosi),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .cs_fall_o  (cs_fall)
  );

  assign cs_act  = ~cs_n_s;
  assign rise    = sck_rise & cs_act;
  assign sh_nxt  = {sh_q[30:0], mosi_s};
  assign cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;

  // Frame decoder: cnt_nxt is the edge count including this edge.
  always_comb begin
    fr_d   = fr_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    wr_d   = wr_q;
    a_d    = a_q;
    iss_rd = 1'b0;
    iss_wr = 1'b0;
    ld_tx  = 1'b0;
    if (rise) begin
      sh_d  = sh_nxt;
      cnt_d = cnt_nxt;
    end
    if (!cs_act) begin
      fr_d  = FR_IDLE;
      cnt_d = '0;
    end else if (cs_fall) begin
      fr_d  = FR_CMD;
      cnt_d = '0;
    end else begin
      unique case (fr_q)
        FR_IDLE: fr_d = FR_CMD;
        FR_CMD: begin
          if (rise && cnt_nxt == CMD_END_BIT) begin
            wr_d = sh_nxt[CMD_WRITE_BIT];
            fr_d = FR_ADDR;
          end
        end
        FR_ADDR: begin
          if (rise && cnt_nxt == RD_ISSUE_BIT) begin
            a_d    = sh_nxt[7:0];
            iss_rd = ~wr_q;
            fr_d   = FR_DATA;
          end
        end
        FR_DATA: begin
          if (rise) begin
            if (wr_q && cnt_nxt == WR_ISSUE_BIT) begin
              iss_wr = 1'b1;
              fr_d   = FR_DRAIN;
            end
            if (!wr_q && cnt_nxt == RD_LOAD_BIT)
              ld_tx = 1'b1;
            if (!wr_q && cnt_nxt == RD_END_BIT)
              fr_d = FR_DRAIN;
          end
        end
        FR_DRAIN: fr_d = FR_DRAIN;
        default:  fr_d = FR_IDLE;
      endcase
    end
  end

  // Bus FSM: triggers arriving while busy are dropped.
  always_comb begin
    bus_d = bus_q;
    tmo_d = tmo_q;
    adr_d = adr_q;
    dat_d = dat_q;
    we_d  = we_q;
    rd_d  = rd_q;
    to_d  = 1'b0;
    unique case (bus_q)
      BUS_IDLE: begin
        if (iss_rd || iss_wr) begin
          bus_d = BUS_REQ;
          tmo_d = '0;
          we_d  = iss_wr;
          adr_d = word_addr(ADDR_BASE,
                            iss_wr ? a_q : sh_nxt[7:0]);
          if (iss_wr)
            dat_d = sh_nxt;
          else
            rd_d = RD_DEFAULT;
        end
      end
      BUS_REQ: begin
        if (wb.ack) begin
          bus_d = BUS_IDLE;
          if (!we_q)
            rd_d = wb.rdat;
        end else if (tmo_q == TMO_LAST) begin
          bus_d = BUS_IDLE;
          to_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  // MISO leads by half a bit: shifted on SCK fall, sampled on rise.
  always_comb begin
    tx_d   = tx_q;
    miso_d = miso_q;
    if (!cs_act) begin
      tx_d   = '0;
      miso_d = 1'b0;
    end else if (ld_tx) begin
      tx_d = rd_q;
    end else if (sck_fall) begin
      miso_d = tx_q[31];
      tx_d   = {tx_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_q   <= FR_IDLE;
      bus_q  <= BUS_IDLE;
      cnt_q  <= '0;
      sh_q   <= '0;
      wr_q   <= 1'b0;
      a_q    <= '0;
      tmo_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      we_q   <= 1'b0;
      rd_q   <= RD_DEFAULT;
      tx_q   <= '0;
      miso_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      fr_q   <= fr_d;
      bus_q  <= bus_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      wr_q   <= wr_d;
      a_q    <= a_d;
      tmo_q  <= tmo_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      tx_q   <= tx_d;
      miso_q <= miso_d;
      to_q   <= to_d;
    end
  end

  assign wb.cyc      = (bus_q == BUS_REQ);
  assign wb.stb      = (bus_q == BUS_REQ);
  assign wb.adr      = adr_q;
  assign wb.wdat     = dat_q;
  assign wb.we       = we_q;
  assign wb.sel      = WB_SEL_ALL;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = cs_act;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_spi_wb_master.sv
// Scoreboard bench for spi_wb_master: SPI master driver, WB slave model,
// WB-cycle and MISO-byte monitors popping expected queues.
module tb_spi_wb_master;

  localparam int H = 5;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic spi_miso_oe;
  logic timeout_o;

  spi_wb_if wb ();

  spi_wb_master #(
    .ADDR_BASE      (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wb          (wb),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  wb_exp_t    exp_wb[$];
  logic [7:0] exp_miso[$];

  int cyc_cnt = 0;
  int run_len = 0;
  int last_len = 0;
  int tmo_hi = 0;

  bit         ack_en = 1'b1;
  int         ack_dly = 1;
  logic [2:0] gpio = 3'b000;
  logic [31:0] scratch = 32'h0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Wishbone slave: GPIO at A0, set A1, clear A2, scratch A3.
  initial begin : slave
    int wcnt;
    bit acked;
    logic [7:0] a;
    wcnt = 0;
    acked = 1'b0;
    wb.ack = 1'b0;
    wb.rdat = '0;
    forever begin
      @(negedge clk);
      wb.ack = 1'b0;
      if (!wb.cyc) begin
        wcnt = 0;
        acked = 1'b0;
      end else if (ack_en && !acked) begin
        if (wcnt >= ack_dly) begin
          wb.ack = 1'b1;
          acked = 1'b1;
          a = wb.adr[9:2];
          if (wb.we) begin
            case (a)
              8'd0: gpio = wb.wdat[2:0];
              8'd1: gpio = gpio | wb.wdat[2:0];
              8'd2: gpio = gpio & ~wb.wdat[2:0];
              8'd3: scratch = wb.wdat;
              default: ;
            endcase
          end else begin
            case (a)
              8'd0: wb.rdat = {29'b0, gpio};
              8'd3: wb.rdat = scratch;
              default: wb.rdat = 32'h0;
            endcase
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // WB monitor: checks each cycle as it starts; tracks lengths/timeouts.
  initial begin : wb_mon
    logic cyc_prev;
    wb_exp_t e;
    cyc_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (timeout_o) tmo_hi++;
      if (wb.cyc) begin
        run_len++;
      end else if (run_len > 0) begin
        last_len = run_len;
        run_len = 0;
      end
      if (wb.cyc && !cyc_prev) begin
        cyc_cnt++;
        if (exp_wb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL wb_unexpected: got cycle adr %h, expected none",
                   wb.adr);
        end else begin
          e = exp_wb.pop_front();
          chk("wb_adr", wb.adr, e.adr);
          chk("wb_we", {31'b0, wb.we}, {31'b0, e.we});
          chk("wb_sel", {28'b0, wb.sel}, 32'hF);
          chk("wb_stb", {31'b0, wb.stb}, 32'h1);
          if (e.we) chk("wb_dat", wb.wdat, e.dat);
        end
      end
      cyc_prev = wb.cyc;
    end
  end

  // MISO monitor: samples on SCK rise, compares each full byte.
  initial begin : miso_mon
    int nb;
    logic [7:0] msh;
    logic [7:0] e;
    nb = 0;
    msh = '0;
    forever begin
      @(posedge spi_sclk or posedge spi_cs_n);
      if (spi_cs_n) begin
        nb = 0;
      end else begin
        msh = {msh[6:0], spi_miso};
        nb++;
        if (nb % 8 == 0) begin
          if (exp_miso.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL miso_unexpected: got %h, expected none", msh);
          end else begin
            e = exp_miso.pop_front();
            chk("miso_byte", {24'b0, msh}, {24'b0, e});
          end
        end
      end
    end
  end

  // Left-aligned frame: bit i of the frame is mo[63-i].
  task automatic spi_frame(input logic [63:0] mo,
                           input logic [63:0] me,
                           input int nbits,
                           input bit keep_cs);
    for (int b = 0; b < nbits / 8; b++)
      exp_miso.push_back(me[63-8*b -: 8]);
    @(negedge clk);
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[63-i];
      repeat (H) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (H) @(negedge clk);
      spi_sclk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (H) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [31:0] d);
    exp_wb.push_back('{word_adr(a), 1'b1, d});
    spi_frame({8'h80, a, d, 16'h0}, 64'h0, 48, 1'b0);
  endtask

  task automatic rd_frame(input logic [7:0] a, input logic [31:0] d);
    exp_wb.push_back('{word_adr(a), 1'b0, 32'h0});
    spi_frame({8'h00, a, 48'h0}, {24'h0, d, 8'h0}, 56, 1'b0);
  endtask

  function automatic logic [31:0] word_adr(input logic [7:0] a);
    return {22'b0, a, 2'b00};
  endfunction

  initial begin : watchdog
    repeat (60000) @(negedge clk);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit found;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cyc", {31'b0, wb.cyc}, 32'h0);
    chk("rst_stb", {31'b0, wb.stb}, 32'h0);
    chk("rst_we", {31'b0, wb.we}, 32'h0);
    chk("rst_adr", wb.adr, 32'h0);
    chk("rst_dat", wb.wdat, 32'h0);
    chk("rst_sel", {28'b0, wb.sel}, 32'hF);
    chk("rst_miso", {31'b0, spi_miso}, 32'h0);
    chk("rst_oe", {31'b0, spi_miso_oe}, 32'h0);
    chk("rst_tmo", {31'b0, timeout_o}, 32'h0);

    ack_en = 1'b1;
    ack_dly = 1;
    wr_frame(8'h00, 32'h0000_0005);
    chk("wr_gpio", {29'b0, gpio}, 32'h5);
    chk("wr_cycles", cyc_cnt, 1);
    chk("wr_no_tmo", tmo_hi, 0);

    ack_dly = 2;
    rd_frame(8'h00, 32'h0000_0005);
    chk("rd_cycles", cyc_cnt, 2);

    ack_en = 1'b0;
    rd_frame(8'h00, 32'hFFFF_FFFF);
    chk("tmo_len", last_len, 16);
    chk("tmo_pulses", tmo_hi, 1);
    chk("tmo_cycles", cyc_cnt, 3);
    ack_en = 1'b1;

    ack_dly = 1;
    spi_frame({8'h80, 8'h01, 32'h1234_5678, 16'h0}, 64'h0, 40, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_cycles", cyc_cnt, 3);
    chk("abort_gpio", {29'b0, gpio}, 32'h5);

    wr_frame(8'h03, 32'hDEAD_BEEF);
    chk("a3_scratch", scratch, 32'hDEAD_BEEF);
    chk("a3_cycles", cyc_cnt, 4);

    ack_dly = 0;
    rd_frame(8'h03, 32'hDEAD_BEEF);

    ack_en = 1'b0;
    exp_wb.push_back('{32'h0, 1'b0, 32'h0});
    spi_frame({8'h00, 8'h00, 48'h0}, 64'h0, 16, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (wb.cyc) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_wait_cyc", {31'b0, found}, 32'h1);
    chk("rst_pre_oe", {31'b0, spi_miso_oe}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cyc", {31'b0, wb.cyc}, 32'h0);
    chk("rst_mid_stb", {31'b0, wb.stb}, 32'h0);
    chk("rst_mid_oe", {31'b0, spi_miso_oe}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    chk("rst_cycles", cyc_cnt, 6);
    ack_en = 1'b1;

    ack_dly = 1;
    wr_frame(8'h00, 32'h0000_0000);
    chk("post_rst_gpio", {29'b0, gpio}, 32'h0);
    wr_frame(8'h01, 32'h0000_0001);
    chk("set_gpio", {29'b0, gpio}, 32'h1);
    wr_frame(8'h02, 32'h0000_0001);
    chk("clr_gpio", {29'b0, gpio}, 32'h0);
    chk("b2b_cycles", cyc_cnt, 9);

    repeat (20) @(negedge clk);
    chk("wb_queue_empty", exp_wb.size(), 0);
    chk("miso_queue_empty", exp_miso.size(), 0);
    chk("final_tmo_pulses", tmo_hi, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
